// File: rtl/spi_master_driver_pkg.sv
// spi_master_driver_pkg: shared SPI state encoding, mode-0 constants and slave-select level helper
package spi_master_driver_pkg;
  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOW   = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_e;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  function automatic logic ss_level(input logic active_low, input logic active);
    return active ^ active_low;
  endfunction
endpackage

// File: rtl/spi_master_driver_if.sv
// spi_master_driver_if: user handshake and SPI pin bundle; master = driver side, slave = user/pin side
interface spi_master_driver_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     send_enable;
  logic                     bus_ready;
  logic                     miso_new_data;
  logic [NUM_DATA_BITS-1:0] mosi_data;
  logic [NUM_DATA_BITS-1:0] miso_data;
  logic                     ss_out;
  logic                     sclk_out;
  logic                     mosi_out;
  logic                     miso_in;
  modport master (
    input  send_enable, mosi_data, miso_in,
    output bus_ready, miso_new_data, miso_data, ss_out, sclk_out, mosi_out
  );
  modport slave (
    output send_enable, mosi_data, miso_in,
    input  bus_ready, miso_new_data, miso_data, ss_out, sclk_out, mosi_out
  );
endinterface

// File: rtl/spi_master_driver_sclk_gen.sv
// spi_sclk_gen: counts SCLK_DIV cycles per FSM phase and emits a one-cycle phase_tick, cleared on state change
module spi_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase_tick
);
  localparam int PW = $clog2(SCLK_DIV + 1);
  logic [PW-1:0] cnt_q, cnt_d;
  always_comb begin
    phase_tick = en && cnt_q == PW'(SCLK_DIV - 1);
    cnt_d = (clr || !en || phase_tick) ? '0 : cnt_q + PW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI mode-0 master driver (FSM, bit counter, shift/capture regs); SPI_MASTER_ABORT_EN adds abort port
module spi_master_driver
  import spi_master_driver_pkg::*;
#(
  parameter bit SS_ACTIVE_LOW = 1'b1,
  parameter bit LSB_FIRST     = 1'b0,
  parameter int NUM_DATA_BITS = 8,
  parameter int SCLK_DIV      = 2
) (
  input logic sys_clk,
  input logic rst,
`ifdef SPI_MASTER_ABORT_EN
  input logic abort,
`endif
  spi_master_driver_if.master bus
);
  localparam int BW = $clog2(NUM_DATA_BITS + 1);
  localparam int DW = NUM_DATA_BITS;
  state_e state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] sh_q, sh_d, cap_q, cap_d, miso_data_q, miso_data_d;
  logic ss_q, ss_d, sclk_q, sclk_d, ready_q, ready_d, new_q, new_d;
  logic tick, gen_en, gen_clr, abort_req, accept, rise, fall, done, capture, advance;
  assign gen_en = state_q inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD, ST_GAP};
`ifdef SPI_MASTER_ABORT_EN
  assign abort_req = abort && (state_q inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD});
`else
  assign abort_req = 1'b0;
`endif
  spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk(sys_clk),
    .rst(rst),
    .en(gen_en),
    .clr(gen_clr),
    .phase_tick(tick)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE:  state_d = bus.send_enable ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_d = tick ? ST_HIGH : ST_SETUP;
      // the last falling SCLK edge goes straight to HOLD, which serves as the final low half-period
      ST_HIGH:  state_d = tick ? (bit_cnt_q == BW'(NUM_DATA_BITS) ? ST_HOLD : ST_LOW) : ST_HIGH;
      ST_LOW:   state_d = tick ? ST_HIGH : ST_LOW;
      ST_HOLD:  state_d = tick ? ST_GAP : ST_HOLD;
      ST_GAP:   state_d = tick ? ST_IDLE : ST_GAP;
      default:  state_d = ST_RESET;
    endcase
    if (abort_req) state_d = ST_GAP;
    gen_clr = state_d != state_q;
    accept = state_q == ST_IDLE && bus.send_enable;
    rise = state_d == ST_HIGH && state_q != ST_HIGH;
    fall = state_q == ST_HIGH && state_d == ST_LOW;
    done = state_q == ST_HOLD && state_d == ST_GAP && !abort_req;
    capture = SPI_CPHA ? fall : rise;
    advance = SPI_CPHA ? rise : fall;
    bit_cnt_d = accept ? '0 : rise ? bit_cnt_q + BW'(1) : bit_cnt_q;
    sh_d = accept ? bus.mosi_data : advance ? (LSB_FIRST ? sh_q >> 1 : sh_q << 1) : sh_q;
    cap_d = !capture ? cap_q :
            LSB_FIRST ? (cap_q >> 1) | (DW'(bus.miso_in) << (DW - 1)) : (cap_q << 1) | DW'(bus.miso_in);
    miso_data_d = done ? cap_q : miso_data_q;
    new_d = done;
    ss_d = ss_level(SS_ACTIVE_LOW, state_d inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD});
    sclk_d = state_d == ST_HIGH ? ~SPI_CPOL : SPI_CPOL;
    ready_d = state_d == ST_IDLE;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      miso_data_q <= '0;
      ss_q        <= ss_level(SS_ACTIVE_LOW, 1'b0);
      sclk_q      <= SPI_CPOL;
      ready_q     <= 1'b0;
      new_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      miso_data_q <= miso_data_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      ready_q     <= ready_d;
      new_q       <= new_d;
    end
  end
  assign bus.bus_ready     = ready_q;
  assign bus.miso_new_data = new_q;
  assign bus.miso_data     = miso_data_q;
  assign bus.ss_out        = ss_q;
  assign bus.sclk_out      = sclk_q;
  assign bus.mosi_out      = LSB_FIRST ? sh_q[0] : sh_q[DW-1];
endmodule

// File: tb/tb_spi_master_driver.sv
// tb_spi_master_driver: directed checks of the SPI mode-0 master in three configurations
module tb_spi_master_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  spi_master_driver_if #(.NUM_DATA_BITS(8)) a_if ();
  spi_master_driver_if #(.NUM_DATA_BITS(8)) b_if ();
  spi_master_driver_if #(.NUM_DATA_BITS(8)) c_if ();
`ifdef SPI_MASTER_ABORT_EN
  logic a_abort = 1'b0;
`endif
  spi_master_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b0), .NUM_DATA_BITS(8), .SCLK_DIV(2)) dut_a (
    .sys_clk(clk),
    .rst(rst),
`ifdef SPI_MASTER_ABORT_EN
    .abort(a_abort),
`endif
    .bus(a_if)
  );
  spi_master_driver #(.SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b1), .NUM_DATA_BITS(8), .SCLK_DIV(1)) dut_b (
    .sys_clk(clk),
    .rst(rst),
`ifdef SPI_MASTER_ABORT_EN
    .abort(1'b0),
`endif
    .bus(b_if)
  );
  spi_master_driver #(.SS_ACTIVE_LOW(1'b0), .LSB_FIRST(1'b0), .NUM_DATA_BITS(8), .SCLK_DIV(2)) dut_c (
    .sys_clk(clk),
    .rst(rst),
`ifdef SPI_MASTER_ABORT_EN
    .abort(1'b0),
`endif
    .bus(c_if)
  );
  int a_rise = 0, a_base = 0, b_rise = 0, b_base = 0, c_rise = 0, c_base = 0, a_strobes = 0;
  logic [7:0] a_word = 8'h3C, b_word = 8'h80, c_word = 8'hC3;
  logic [7:0] a_mosi = '0, b_mosi = '0, c_mosi = '0;
  logic [7:0] a_tx = 8'hA5;
  logic [2:0] a_idx, b_idx, c_idx;
  always @(posedge a_if.sclk_out) begin
    a_rise <= a_rise + 1;
    a_mosi <= {a_mosi[6:0], a_if.mosi_out};
  end
  always @(posedge b_if.sclk_out) begin
    b_rise <= b_rise + 1;
    b_mosi <= {b_if.mosi_out, b_mosi[7:1]};
  end
  always @(posedge c_if.sclk_out) begin
    c_rise <= c_rise + 1;
    c_mosi <= {c_mosi[6:0], c_if.mosi_out};
  end
  always @(posedge clk) if (a_if.miso_new_data) a_strobes <= a_strobes + 1;
  assign a_idx = 3'(a_rise - a_base);
  assign b_idx = 3'(b_rise - b_base);
  assign c_idx = 3'(c_rise - c_base);
  assign a_if.miso_in = a_word[3'd7 - a_idx];
  assign b_if.miso_in = b_word[b_idx];
  assign c_if.miso_in = c_word[3'd7 - c_idx];
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // {ss, sclk, bus_ready, miso_new_data} after edge k of an 8-bit frame with half-period d
  function automatic logic [3:0] exp_pins(input int k, input int d, input logic ss_low);
    logic act, sclk, rdy, nd;
    act = k < 17 * d;
    sclk = ((k / d) % 2 == 1) && ((k / d) < 16);
    rdy = k >= 18 * d;
    nd = k == 17 * d;
    return {ss_low ? !act : act, sclk, rdy, nd};
  endfunction
  initial begin
    int n_acc, acc0, acc1, s0;
    logic prev_ready;
    a_if.send_enable = 1'b0;
    b_if.send_enable = 1'b0;
    c_if.send_enable = 1'b0;
    a_if.mosi_data = '0;
    b_if.mosi_data = '0;
    c_if.mosi_data = '0;
    cyc();
    cyc();
    chk("rst_a_pins", 32'({a_if.ss_out, a_if.sclk_out, a_if.mosi_out, a_if.bus_ready, a_if.miso_new_data}), 32'(5'b10000));
    chk("rst_a_miso_data", 32'(a_if.miso_data), 32'(0));
    chk("rst_c_ss_idle", 32'(c_if.ss_out), 32'(0));
    rst = 1'b0;
    cyc();
    chk("rst_release_ready", 32'({a_if.bus_ready, b_if.bus_ready, c_if.bus_ready}), 32'(3'b111));
    a_base = a_rise;
    a_if.mosi_data = a_tx;
    a_if.send_enable = 1'b1;
    cyc();
    a_if.send_enable = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      chk("a_pins", 32'({a_if.ss_out, a_if.sclk_out, a_if.bus_ready, a_if.miso_new_data}), 32'(exp_pins(k, 2, 1'b1)));
      if (k % 4 == 2 && k < 32) chk("a_mosi_bit", 32'(a_if.mosi_out), 32'(a_tx[3'(7 - k / 4)]));
      if (k == 34) chk("a_miso_data", 32'(a_if.miso_data), 32'(8'h3C));
      if (k < 36) cyc();
    end
    chk("a_mosi_word", 32'(a_mosi), 32'(8'hA5));
    a_base = a_rise;
    n_acc = 0;
    acc0 = -1;
    acc1 = -1;
    prev_ready = a_if.bus_ready;
    a_if.send_enable = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (prev_ready && !a_if.bus_ready) begin
        if (n_acc == 0) acc0 = k;
        else if (n_acc == 1) acc1 = k;
        n_acc++;
      end
      prev_ready = a_if.bus_ready;
    end
    a_if.send_enable = 1'b0;
    chk("held_accept_count", 32'(n_acc), 32'(2));
    chk("held_accept_first", 32'(acc0), 32'(0));
    chk("held_accept_second", 32'(acc1), 32'(37));
    repeat (20) cyc();
    chk("held_ready_after", 32'(a_if.bus_ready), 32'(1));
    chk("held_miso_data", 32'(a_if.miso_data), 32'(8'h3C));
`ifdef SPI_MASTER_ABORT_EN
    s0 = a_strobes;
    a_base = a_rise;
    a_if.mosi_data = 8'hFF;
    a_if.send_enable = 1'b1;
    cyc();
    a_if.send_enable = 1'b0;
    repeat (12) cyc();
    a_abort = 1'b1;
    cyc();
    a_abort = 1'b0;
    chk("abort_ss_sclk_ready", 32'({a_if.ss_out, a_if.sclk_out, a_if.bus_ready}), 32'(3'b100));
    cyc();
    chk("abort_ready_e14", 32'(a_if.bus_ready), 32'(0));
    cyc();
    chk("abort_ready_e15", 32'(a_if.bus_ready), 32'(1));
    repeat (5) cyc();
    chk("abort_no_strobe", 32'(a_strobes - s0), 32'(0));
    chk("abort_miso_kept", 32'(a_if.miso_data), 32'(8'h3C));
`endif
    s0 = a_strobes;
    a_base = a_rise;
    a_if.mosi_data = 8'h81;
    a_if.send_enable = 1'b1;
    cyc();
    a_if.send_enable = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_pins", 32'({a_if.ss_out, a_if.sclk_out, a_if.mosi_out, a_if.bus_ready, a_if.miso_new_data}), 32'(5'b10000));
    chk("midrst_miso_data", 32'(a_if.miso_data), 32'(0));
    cyc();
    chk("midrst_ready", 32'(a_if.bus_ready), 32'(1));
    repeat (40) cyc();
    chk("midrst_no_strobe", 32'(a_strobes - s0), 32'(0));
    b_base = b_rise;
    b_if.mosi_data = 8'h01;
    b_if.send_enable = 1'b1;
    cyc();
    b_if.send_enable = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      chk("b_pins", 32'({b_if.ss_out, b_if.sclk_out, b_if.bus_ready, b_if.miso_new_data}), 32'(exp_pins(k, 1, 1'b1)));
      if (k == 0) chk("b_first_mosi", 32'(b_if.mosi_out), 32'(1));
      if (k < 18) cyc();
    end
    chk("b_miso_data", 32'(b_if.miso_data), 32'(8'h80));
    chk("b_mosi_word", 32'(b_mosi), 32'(8'h01));
    c_base = c_rise;
    c_if.mosi_data = 8'h5A;
    c_if.send_enable = 1'b1;
    cyc();
    c_if.send_enable = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      chk("c_pins", 32'({c_if.ss_out, c_if.sclk_out, c_if.bus_ready, c_if.miso_new_data}), 32'(exp_pins(k, 2, 1'b0)));
      if (k < 36) cyc();
    end
    chk("c_miso_data", 32'(c_if.miso_data), 32'(8'hC3));
    chk("c_mosi_word", 32'(c_mosi), 32'(8'h5A));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
